// File: rtl/instruction_memory_loadable.sv
// Run-time loadable instruction memory for the single-cycle MIPS core.
// Combinational fetch, streaming load port, post-reset clear sweep and busy hold.
module instruction_memory_loadable #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000000,
    localparam int                   IDX_W      = $clog2(DEPTH),
    localparam int                   CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_fault,
    output logic                  busy,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic [CNT_W-1:0]      load_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH * 4);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(DEPTH - 1);

    state_t                  state, state_next;
    logic [IDX_W-1:0]        clear_idx, clear_idx_next;
    logic [IDX_W-1:0]        load_ptr, load_ptr_next;
    logic [CNT_W-1:0]        load_count_next;
    logic                    load_done_next;
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [IDX_W-1:0]        fetch_idx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign dbg_state = state;

    // Fault check uses the full address so high garbage bits cannot alias into range.
    assign fetch_fault = (fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_addr} >= ADDR_LIMIT);
    assign fetch_idx   = fetch_addr[IDX_W+1:2];
    assign fetch_instr = (fetch_fault || busy) ? NOP_WORD : mem[fetch_idx];

    // Load handshake: a word transfers on a cycle where load_valid && load_ready
    // are both high; load_ready is high for the whole LOAD state and only there.
    always_comb begin
        state_next      = state;
        clear_idx_next  = clear_idx;
        load_ptr_next   = load_ptr;
        load_count_next = load_count;
        load_done_next  = 1'b0;
        wr_en           = 1'b0;
        wr_idx          = clear_idx;
        wr_data         = NOP_WORD;
        busy            = 1'b1;
        load_ready      = 1'b0;
        case (state)
            ST_CLEAR: begin
                wr_en = 1'b1;
                if (clear_idx == LAST_IDX) begin
                    clear_idx_next = '0;
                    state_next     = ST_IDLE;
                end else begin
                    clear_idx_next = clear_idx + 1'b1;
                end
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (load_start) begin
                    load_ptr_next   = '0;
                    load_count_next = '0;
                    state_next      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    wr_en           = 1'b1;
                    wr_idx          = load_ptr;
                    wr_data         = load_data;
                    load_count_next = load_count + 1'b1;
                    // Pointer is never advanced past the last word, so it cannot wrap.
                    if (load_last || load_ptr == LAST_IDX) begin
                        state_next     = ST_IDLE;
                        load_done_next = 1'b1;
                    end else begin
                        load_ptr_next = load_ptr + 1'b1;
                    end
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CLEAR;
            clear_idx  <= '0;
            load_ptr   <= '0;
            load_count <= '0;
            load_done  <= 1'b0;
        end else begin
            state      <= state_next;
            clear_idx  <= clear_idx_next;
            load_ptr   <= load_ptr_next;
            load_count <= load_count_next;
            load_done  <= load_done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Scoreboard bench for instruction_memory_loadable: directed fetch and load
// vectors push expectations; monitors compare fetch results and load_done pulses.
module tb_instruction_memory_loadable;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_addr = '0;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        busy;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_done;
    logic [5:0]  load_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic fetch_req = 1'b0;

    logic [32:0] exp_q[$];      // {fault, instr}
    logic [37:0] done_q[$];     // {cycle, count}

    instruction_memory_loadable dut (
        .clk(clk), .reset(reset),
        .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
        .busy(busy), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .load_done(load_done), .load_count(load_count), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (fetch_req) begin
            if (exp_q.size() == 0) begin
                check("fetch_q_underflow", 1, 0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("fetch_fault", {63'd0, fetch_fault}, {63'd0, e[32]});
                check("fetch_instr", {32'd0, fetch_instr}, {32'd0, e[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (load_done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("unexpected_load_done", 1, 0);
            end else begin
                logic [37:0] d;
                d = done_q.pop_front();
                check("load_done_cycle", 64'(cyc), 64'(d[37:6]));
                check("load_count", {58'd0, load_count}, {58'd0, d[5:0]});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic f, input logic [31:0] instr);
        fetch_addr = a;
        exp_q.push_back({f, instr});
        fetch_req = 1'b1;
        @(negedge clk);
        #1 fetch_req = 1'b0;
        tick();
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input bit exp_done,
                             input int exp_cnt);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        if (exp_done) done_q.push_back({32'(cyc + 1), 6'(exp_cnt)});
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Reset (with load inputs active, which must lose), then time the clear sweep.
    task automatic reset_sweep(input bit poke_start);
        int n;
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hBAD0BAD0;
        tick();
        check("rst_busy", {63'd0, busy}, 1);
        check("rst_load_ready", {63'd0, load_ready}, 0);
        check("rst_load_done", {63'd0, load_done}, 0);
        check("rst_load_count", {58'd0, load_count}, 0);
        check("rst_state", {62'd0, dbg_state}, 0);
        reset      = 1'b0;
        load_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (poke_start && n == 5) load_start = 1'b1;
            if (poke_start && n == 6) load_start = 1'b0;
        end
        check("busy_cycles", 64'(n), 32);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1: reset and clear sweep
        reset_sweep(0);
        check("idle_state", {62'd0, dbg_state}, 1);
        fetch(32'h00, 0, 32'h0);
        fetch(32'h04, 0, 32'h0);
        fetch(32'h7C, 0, 32'h0);

        // 2: three-word session with load_last
        start_load();
        check("load_ready", {63'd0, load_ready}, 1);
        send_word(32'h2008000a, 0, 0, 0);
        send_word(32'h20090005, 0, 0, 0);
        send_word(32'h01095020, 1, 1, 3);
        tick();
        check("busy_after_load", {63'd0, busy}, 0);
        check("count_held", {58'd0, load_count}, 3);
        fetch(32'h0, 0, 32'h2008000a);
        fetch(32'h4, 0, 32'h20090005);
        fetch(32'h8, 0, 32'h01095020);
        fetch(32'hC, 0, 32'h0);

        // 3: gaps in the stream; fetch during LOAD sees NOP
        start_load();
        send_word(32'h11111111, 0, 0, 0);
        fetch(32'h0, 0, 32'h0);
        tick();
        tick();
        send_word(32'h22222222, 1, 1, 2);
        fetch(32'h0, 0, 32'h11111111);
        fetch(32'h4, 0, 32'h22222222);
        fetch(32'h8, 0, 32'h01095020);

        // 4: fault boundaries
        fetch(32'h06, 1, 32'h0);
        fetch(32'h80, 1, 32'h0);
        fetch(32'h7C, 0, 32'h0);
        fetch(32'hFFFFFFFC, 1, 32'h0);

        // 5: full-memory auto end, then ignored beats in IDLE
        start_load();
        for (int i = 0; i < 32; i++) begin
            send_word(32'hA0000000 + 32'(i), 0, (i == 31), 32);
        end
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        tick();
        load_valid = 1'b0;
        fetch(32'h00, 0, 32'hA0000000);
        fetch(32'h7C, 0, 32'hA000001F);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hBADBAD00;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        send_word(32'h33333333, 1, 1, 1);
        fetch(32'h00, 0, 32'h33333333);
        fetch(32'h04, 0, 32'hA0000001);

        // 6: reset aborts a session; load_start during CLEAR ignored
        start_load();
        send_word(32'h44444444, 0, 0, 0);
        send_word(32'h55555555, 0, 0, 0);
        reset_sweep(1);
        check("state_after_sweep", {62'd0, dbg_state}, 1);
        check("count_after_abort", {58'd0, load_count}, 0);
        fetch(32'h0, 0, 32'h0);
        fetch(32'h4, 0, 32'h0);

        tick();
        check("fetch_q_drained", 64'(exp_q.size()), 0);
        check("done_q_drained", 64'(done_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
